// File: rtl/ram_pkg.sv
// Shared constants for the 32 x 32-bit data RAM and the ram_copy_engine sequencer.
package ram_pkg;

  localparam int RAM_AW = 5;
  localparam int RAM_DW = 32;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_COPY = 1'b1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_CAP  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  typedef logic [RAM_AW-1:0] ram_addr_t;
  typedef logic [RAM_DW-1:0] ram_word_t;

endpackage

// File: rtl/ram_copy_engine_if.sv
// Pin bundle between a RAM bus master (the copy engine) and the single-port ram.
interface ram_copy_engine_if #(
  parameter int AW = 5,
  parameter int DW = 32
) ();

  logic          ram_ena;
  logic          wena;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;

  modport master (
    output ram_ena,
    output wena,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  ram_ena,
    input  wena,
    input  addr,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/ram.sv
// Single-port synchronous RAM: write on enabled edge, read data valid one clock later.
module ram #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          ram_ena,
  input  logic          wena,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (ram_ena) begin
      if (wena) begin
        mem[addr] <= data_in;
      end else begin
        data_out <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ram_copy_engine.sv
// Fill / copy sequencer driving the single-port ram; optional XOR checksum of
// written words is enabled with `define RAM_COPY_CHECKSUM_EN.
module ram_copy_engine
  import ram_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_data,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] checksum,
  ram_copy_engine_if.master bus
);

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   MAX_LEN = {1'b1, {AW{1'b0}}};

  logic [2:0]    state;
  logic          op_q;
  logic [AW:0]   cnt;
  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic          busy_q;
  logic          done_q;
  logic          ram_ena_q;
  logic          wena_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_in_q;
  logic [AW:0]   len_clamped;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

  // Outputs are registered together with the state they belong to, so each
  // transition loads the bus values for the cycle it enters. data_in_q doubles
  // as the copy buffer: it captures data_out on the CAP -> WR edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_FILL;
      cnt       <= '0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ram_ena_q <= 1'b0;
      wena_q    <= 1'b0;
      addr_q    <= '0;
      data_in_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= op;
            cnt  <= len_clamped;
            if (len_clamped == '0) begin
              state  <= ST_FIN;
              done_q <= 1'b1;
            end else if (op == OP_FILL) begin
              state     <= ST_WR;
              busy_q    <= 1'b1;
              ram_ena_q <= 1'b1;
              wena_q    <= 1'b1;
              addr_q    <= dst_addr;
              data_in_q <= fill_data;
              dst_ptr   <= dst_addr + PTR_ONE;
              src_ptr   <= src_addr;
            end else begin
              state     <= ST_RD;
              busy_q    <= 1'b1;
              ram_ena_q <= 1'b1;
              wena_q    <= 1'b0;
              addr_q    <= src_addr;
              src_ptr   <= src_addr + PTR_ONE;
              dst_ptr   <= dst_addr;
            end
          end
        end
        ST_RD: begin
          state     <= ST_CAP;
          ram_ena_q <= 1'b0;
          wena_q    <= 1'b0;
        end
        ST_CAP: begin
          state     <= ST_WR;
          ram_ena_q <= 1'b1;
          wena_q    <= 1'b1;
          addr_q    <= dst_ptr;
          data_in_q <= bus.data_out;
          dst_ptr   <= dst_ptr + PTR_ONE;
        end
        ST_WR: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state     <= ST_FIN;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            ram_ena_q <= 1'b0;
            wena_q    <= 1'b0;
          end else if (op_q == OP_FILL) begin
            addr_q  <= dst_ptr;
            dst_ptr <= dst_ptr + PTR_ONE;
          end else begin
            state   <= ST_RD;
            wena_q  <= 1'b0;
            addr_q  <= src_ptr;
            src_ptr <= src_ptr + PTR_ONE;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign bus.ram_ena = ram_ena_q;
  assign bus.wena    = wena_q;
  assign bus.addr    = addr_q;
  assign bus.data_in = data_in_q;

`ifdef RAM_COPY_CHECKSUM_EN
  logic [DW-1:0] csum_q;

  // Folds in the word leaving the bus at the end of each WR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (state == ST_IDLE && start) begin
      csum_q <= '0;
    end else if (state == ST_WR) begin
      csum_q <= csum_q ^ data_in_q;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench: ram_copy_engine wired pin-to-pin to the ram model.
module tb_ram_copy_engine;
  import ram_pkg::*;

`ifdef RAM_COPY_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [4:0]  src_addr;
  logic [4:0]  dst_addr;
  logic [5:0]  len;
  logic [31:0] fill_data;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;

  ram_copy_engine_if #(.AW(5), .DW(32)) bus ();

  ram_copy_engine #(.AW(5), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .fill_data (fill_data),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .bus       (bus.master)
  );

  ram #(.AW(5), .DW(32)) u_ram (
    .clk      (clk),
    .ram_ena  (bus.ram_ena),
    .wena     (bus.wena),
    .addr     (bus.addr),
    .data_in  (bus.data_in),
    .data_out (bus.data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1; start is sampled at the next edge (edge 0).
  task automatic issue_cmd(input logic o, input logic [4:0] s, input logic [4:0] d,
                           input logic [5:0] l, input logic [31:0] f);
    op = o; src_addr = s; dst_addr = d; len = l; fill_data = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int first_cyc, output int done_cyc,
                           output int busy_cnt, output int ena_cnt);
    int cyc;
    cyc = first_cyc;
    done_cyc = -1;
    busy_cnt = 0;
    ena_cnt = 0;
    while (cyc < first_cyc + 200) begin
      if (busy) busy_cnt++;
      if (bus.ram_ena) ena_cnt++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_status busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (bus.ram_ena !== 1'b0 || bus.wena !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ena ram_ena=%b wena=%b required 0 0", bus.ram_ena, bus.wena);
    end
    checks++;
    if (bus.addr !== 5'd0 || bus.data_in !== 32'd0 || checksum !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_bus addr=%0d data_in=%h checksum=%h required 0", bus.addr, bus.data_in, checksum);
    end
  endtask

  // len=40 clamps to 32 and clears every word, giving known RAM contents.
  task automatic test_clamp_fill;
    int dc, bc, ec;
    issue_cmd(OP_FILL, 5'd0, 5'd7, 6'd40, 32'h0);
    wait_done(1, dc, bc, ec);
    checks++;
    if (dc !== 33) begin
      errors++; $display("[TB] FAIL clamp_done_cycle got %0d required 33", dc);
    end
    checks++;
    if (bc !== 32) begin
      errors++; $display("[TB] FAIL clamp_busy_cycles got %0d required 32", bc);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (u_ram.mem[i] !== 32'h0) begin
        errors++; $display("[TB] FAIL clamp_word%0d got %h required 0", i, u_ram.mem[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill;
    int dc, bc, ec;
    issue_cmd(OP_FILL, 5'd0, 5'd2, 6'd3, 32'h0000000A);
    wait_done(1, dc, bc, ec);
    checks++;
    if (dc !== 4) begin
      errors++; $display("[TB] FAIL fill_done_cycle got %0d required 4", dc);
    end
    checks++;
    if (bc !== 3) begin
      errors++; $display("[TB] FAIL fill_busy_cycles got %0d required 3", bc);
    end
    checks++;
    if (checksum !== (CSUM_ON ? 32'h0000000A : 32'h0)) begin
      errors++; $display("[TB] FAIL fill_checksum got %h required %h", checksum, CSUM_ON ? 32'h0000000A : 32'h0);
    end
    for (int i = 2; i <= 5; i++) begin
      checks++;
      if (u_ram.mem[i] !== ((i <= 4) ? 32'h0000000A : 32'h0)) begin
        errors++; $display("[TB] FAIL fill_word%0d got %h required %h", i, u_ram.mem[i], (i <= 4) ? 32'h0000000A : 32'h0);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic preload_source;
    int dc, bc, ec;
    logic [31:0] vals [4];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      issue_cmd(OP_FILL, 5'd0, 5'(i), 6'd1, vals[i]);
      wait_done(1, dc, bc, ec);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_copy;
    int dc, bc, ec;
    logic [31:0] exp;
    issue_cmd(OP_COPY, 5'd0, 5'd8, 6'd4, 32'hDEADBEEF);
    wait_done(1, dc, bc, ec);
    checks++;
    if (dc !== 13) begin
      errors++; $display("[TB] FAIL copy_done_cycle got %0d required 13", dc);
    end
    checks++;
    if (bc !== 12) begin
      errors++; $display("[TB] FAIL copy_busy_cycles got %0d required 12", bc);
    end
    checks++;
    if (ec !== 8) begin
      errors++; $display("[TB] FAIL copy_ena_cycles got %0d required 8", ec);
    end
    for (int i = 0; i < 4; i++) begin
      exp = 32'h11 * (i + 1);
      checks++;
      if (u_ram.mem[8 + i] !== exp) begin
        errors++; $display("[TB] FAIL copy_word%0d got %h required %h", 8 + i, u_ram.mem[8 + i], exp);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (checksum !== (CSUM_ON ? 32'h44 : 32'h0) || done !== 1'b0) begin
      errors++; $display("[TB] FAIL copy_checksum_after got %h done=%b required %h done=0", checksum, done, CSUM_ON ? 32'h44 : 32'h0);
    end
  endtask

  task automatic test_wrap;
    int dc, bc, ec;
    issue_cmd(OP_FILL, 5'd0, 5'd30, 6'd4, 32'hFFFFFFFF);
    wait_done(1, dc, bc, ec);
    checks++;
    if (dc !== 5) begin
      errors++; $display("[TB] FAIL wrap_done_cycle got %0d required 5", dc);
    end
    checks++;
    if (u_ram.mem[30] !== 32'hFFFFFFFF || u_ram.mem[31] !== 32'hFFFFFFFF ||
        u_ram.mem[0] !== 32'hFFFFFFFF || u_ram.mem[1] !== 32'hFFFFFFFF) begin
      errors++; $display("[TB] FAIL wrap_words got %h %h %h %h required all ffffffff",
                         u_ram.mem[30], u_ram.mem[31], u_ram.mem[0], u_ram.mem[1]);
    end
    checks++;
    if (u_ram.mem[2] !== 32'h33 || u_ram.mem[29] !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_neighbours got w2=%h w29=%h required 33 0", u_ram.mem[2], u_ram.mem[29]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_len;
    int dc, bc, ec;
    issue_cmd(OP_COPY, 5'd3, 5'd12, 6'd0, 32'h0);
    wait_done(1, dc, bc, ec);
    checks++;
    if (dc !== 1) begin
      errors++; $display("[TB] FAIL zero_done_cycle got %0d required 1", dc);
    end
    checks++;
    if (bc !== 0 || ec !== 0) begin
      errors++; $display("[TB] FAIL zero_activity busy=%0d ena=%0d required 0 0", bc, ec);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.ram_ena !== 1'b0 || done !== 1'b0 || checksum !== 32'h0) begin
      errors++; $display("[TB] FAIL zero_after ram_ena=%b done=%b checksum=%h required 0 0 0", bus.ram_ena, done, checksum);
    end
  endtask

  task automatic test_ignored_start;
    int dc, bc, ec;
    issue_cmd(OP_COPY, 5'd0, 5'd16, 6'd4, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    issue_cmd(OP_FILL, 5'd0, 5'd16, 6'd2, 32'h0000DEAD);
    wait_done(5, dc, bc, ec);
    checks++;
    if (dc !== 13) begin
      errors++; $display("[TB] FAIL ignored_done_cycle got %0d required 13", dc);
    end
    checks++;
    if (u_ram.mem[16] !== 32'hFFFFFFFF || u_ram.mem[17] !== 32'hFFFFFFFF ||
        u_ram.mem[18] !== 32'h33 || u_ram.mem[19] !== 32'h44) begin
      errors++; $display("[TB] FAIL ignored_words got %h %h %h %h required ffffffff ffffffff 33 44",
                         u_ram.mem[16], u_ram.mem[17], u_ram.mem[18], u_ram.mem[19]);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL ignored_not_queued busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_copy;
    int dc, bc, ec;
    int done_seen;
    issue_cmd(OP_COPY, 5'd8, 5'd20, 6'd4, 32'h0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bus.ram_ena !== 1'b0 || bus.wena !== 1'b0 ||
        bus.addr !== 5'd0 || bus.data_in !== 32'd0 || checksum !== 32'd0) begin
      errors++; $display("[TB] FAIL midreset_outputs busy=%b done=%b ena=%b wena=%b addr=%0d din=%h cs=%h required all 0",
                         busy, done, bus.ram_ena, bus.wena, bus.addr, bus.data_in, checksum);
    end
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++; $display("[TB] FAIL midreset_done_pulses got %0d required 0", done_seen);
    end
    checks++;
    if (u_ram.mem[20] !== 32'h11 || u_ram.mem[21] !== 32'h0) begin
      errors++; $display("[TB] FAIL midreset_words got w20=%h w21=%h required 11 0", u_ram.mem[20], u_ram.mem[21]);
    end
    issue_cmd(OP_FILL, 5'd0, 5'd24, 6'd2, 32'h77);
    wait_done(1, dc, bc, ec);
    checks++;
    if (dc !== 3) begin
      errors++; $display("[TB] FAIL postreset_done_cycle got %0d required 3", dc);
    end
    checks++;
    if (u_ram.mem[24] !== 32'h77 || u_ram.mem[25] !== 32'h77 || u_ram.mem[26] !== 32'h0) begin
      errors++; $display("[TB] FAIL postreset_words got %h %h %h required 77 77 0",
                         u_ram.mem[24], u_ram.mem[25], u_ram.mem[26]);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = OP_FILL;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    fill_data = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_clamp_fill();
    test_fill();
    preload_source();
    test_copy();
    test_wrap();
    test_zero_len();
    test_ignored_start();
    test_reset_mid_copy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
